matmul_calc_engine: RTL and testbench

Parametrised successor of the scratchpad matrix-multiply calculator. Loads A rows, B rows and optional C bias from the operand buses, then computes C = A×B (+C) with one signed MAC per cycle. Writes each result element to the scratchpad as soon as it completes, and reports per-element overflow flags. Sits between the register-file/control block (start, mode, dimensions) and the scratchpad write port.

---
 rtl/matmul_calc_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_matmul_calc_engine.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_calc_engine.sv
// matmul_calc_engine
//   Loads A rows, B rows and an optional C bias from the operand buses, then
//   computes C = A x B (+C) with one signed MAC per cycle. Each result
//   element is written to the scratchpad as soon as it completes, and
//   per-element sticky overflow flags are reported.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        level request: rising edge in IDLE starts, low aborts
//   mode_i         1 = add C bias (sampled at start)
//   n/k/m_dim_i    dimension minus one (sampled at start)
//   data_a/b_i     one operand row, lane t at [t*DATA_WIDTH +: DATA_WIDTH]
//   data_c_i       one signed C bias element
//   rd_idx_o       operand index expected on the buses this cycle
//   busy_o         high while loading or computing
//   enable_w_o     scratchpad write strobe
//   address_o      scratchpad write address
//   data_o         scratchpad write data
//   flags_o        sticky overflow flag per element slot
//   finish_mul_o   job complete (level)
//
// Build option
//   MATMUL_SAT_EN  saturate the accumulator on overflow instead of wrapping
module matmul_calc_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  localparam int unsigned MAX_DIM   = BUS_WIDTH / DATA_WIDTH,
  localparam int unsigned DW        = $clog2(MAX_DIM),
  localparam int unsigned EW        = 2 * DW
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [DW-1:0]         n_dim_i,
  input  logic [DW-1:0]         k_dim_i,
  input  logic [DW-1:0]         m_dim_i,
  input  logic [BUS_WIDTH-1:0]  data_a_i,
  input  logic [BUS_WIDTH-1:0]  data_b_i,
  input  logic [BUS_WIDTH-1:0]  data_c_i,
  output logic [EW-1:0]         rd_idx_o,
  output logic                  busy_o,
  output logic                  enable_w_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic [BUS_WIDTH-1:0]  data_o,
  output logic [BUS_WIDTH-1:0]  flags_o,
  output logic                  finish_mul_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DONE} state_e;

  state_e                        state_q;
  logic                          start_q, mode_q, last_q;
  logic [DW-1:0]                 n_q, k_q, m_q;
  logic [DW-1:0]                 ci_q, cj_q, i_q, j_q, t_q;
  logic [EW-1:0]                 l_last_q, rd_idx_q, l_calc, slot;
  logic signed [BUS_WIDTH-1:0]   acc_q, acc_nxt, addend, prod_ext, sum;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]  a_el, b_el;
  logic                          ovf;
  logic                          busy_q, enable_w_q, finish_q;
  logic [ADDR_WIDTH-1:0]         address_q, addr_nxt;
  logic [BUS_WIDTH-1:0]          data_q, flags_q;

  logic signed [DATA_WIDTH-1:0]  a_mat [MAX_DIM][MAX_DIM];
  logic signed [DATA_WIDTH-1:0]  b_mat [MAX_DIM][MAX_DIM];
  logic signed [BUS_WIDTH-1:0]   c_mat [MAX_DIM*MAX_DIM];

`ifdef MATMUL_SAT_EN
  logic sat_q, sat_nxt, sat_hold;
`endif

  // Last LOAD index for the job being started.
  always_comb begin
    l_calc = '0;
    if (mode_i)
      l_calc = EW'((32'(n_dim_i) + 32'd1) * (32'(m_dim_i) + 32'd1) - 32'd1);
    else
      l_calc = (n_dim_i > k_dim_i) ? {{DW{1'b0}}, n_dim_i} : {{DW{1'b0}}, k_dim_i};
  end

  // One MAC step; t == 0 seeds the accumulator from the bias (or zero).
  always_comb begin
    slot     = {i_q, j_q};
    a_el     = a_mat[i_q][t_q];
    b_el     = b_mat[t_q][j_q];
    prod     = a_el * b_el;
    prod_ext = BUS_WIDTH'(prod);
    addend   = (t_q == '0) ? (mode_q ? c_mat[slot] : '0) : acc_q;
    sum      = addend + prod_ext;
    ovf      = (addend[BUS_WIDTH-1] == prod_ext[BUS_WIDTH-1]) &&
               (sum[BUS_WIDTH-1] != addend[BUS_WIDTH-1]);
    addr_nxt          = '0;
    addr_nxt[4:0]     = 5'b10000;
    addr_nxt[5 +: EW] = slot;
`ifdef MATMUL_SAT_EN
    // Once clamped, the element holds its clamped value until written.
    sat_hold = (t_q != '0) && sat_q;
    sat_nxt  = sat_hold || ovf;
    if (sat_hold)
      acc_nxt = acc_q;
    else if (ovf)
      acc_nxt = addend[BUS_WIDTH-1] ? {1'b1, {(BUS_WIDTH-1){1'b0}}}
                                    : {1'b0, {(BUS_WIDTH-1){1'b1}}};
    else
      acc_nxt = sum;
`else
    acc_nxt = sum;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      mode_q     <= 1'b0;
      last_q     <= 1'b0;
      n_q        <= '0;
      k_q        <= '0;
      m_q        <= '0;
      ci_q       <= '0;
      cj_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      t_q        <= '0;
      l_last_q   <= '0;
      rd_idx_q   <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      enable_w_q <= 1'b0;
      finish_q   <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
      flags_q    <= '0;
`ifdef MATMUL_SAT_EN
      sat_q      <= 1'b0;
`endif
      for (int unsigned r = 0; r < MAX_DIM; r++) begin
        for (int unsigned c = 0; c < MAX_DIM; c++) begin
          a_mat[r][c] <= '0;
          b_mat[r][c] <= '0;
        end
      end
      for (int unsigned s = 0; s < MAX_DIM*MAX_DIM; s++) c_mat[s] <= '0;
    end else begin
      start_q    <= start_i;
      enable_w_q <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
      case (state_q)
        S_IDLE: begin
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
          if (start_i && !start_q) begin
            mode_q   <= mode_i;
            n_q      <= n_dim_i;
            k_q      <= k_dim_i;
            m_q      <= m_dim_i;
            l_last_q <= l_calc;
            flags_q  <= '0;
            rd_idx_q <= '0;
            ci_q     <= '0;
            cj_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!start_i) begin
            busy_q   <= 1'b0;
            rd_idx_q <= '0;
            state_q  <= S_IDLE;
          end else begin
            if (rd_idx_q <= {{DW{1'b0}}, n_q})
              for (int unsigned l = 0; l < MAX_DIM; l++)
                a_mat[rd_idx_q[DW-1:0]][l] <= (DW'(l) <= k_q) ?
                  data_a_i[l*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (rd_idx_q <= {{DW{1'b0}}, k_q})
              for (int unsigned l = 0; l < MAX_DIM; l++)
                b_mat[rd_idx_q[DW-1:0]][l] <= (DW'(l) <= m_q) ?
                  data_b_i[l*DATA_WIDTH +: DATA_WIDTH] : '0;
            if (mode_q) begin
              // Bias arrives packed row-major; store it in the MAX_DIM-stride slot.
              c_mat[{ci_q, cj_q}] <= data_c_i;
              if (cj_q == m_q) begin
                cj_q <= '0;
                ci_q <= ci_q + 1'b1;
              end else begin
                cj_q <= cj_q + 1'b1;
              end
            end
            if (rd_idx_q == l_last_q) begin
              rd_idx_q <= '0;
              i_q      <= '0;
              j_q      <= '0;
              t_q      <= '0;
              last_q   <= 1'b0;
              state_q  <= S_COMPUTE;
            end else begin
              rd_idx_q <= rd_idx_q + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (!start_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (last_q) begin
            // Final write strobe is on the outputs this cycle.
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q <= acc_nxt;
`ifdef MATMUL_SAT_EN
            sat_q <= sat_nxt;
`endif
            if (ovf) flags_q[slot] <= 1'b1;
            if (t_q == k_q) begin
              enable_w_q <= 1'b1;
              data_q     <= acc_nxt;
              address_q  <= addr_nxt;
              t_q        <= '0;
              if (j_q == m_q) begin
                j_q <= '0;
                if (i_q == n_q) last_q <= 1'b1;
                else            i_q    <= i_q + 1'b1;
              end else begin
                j_q <= j_q + 1'b1;
              end
            end else begin
              t_q <= t_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!start_i) begin
            finish_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_idx_o     = rd_idx_q;
  assign busy_o       = busy_q;
  assign enable_w_o   = enable_w_q;
  assign address_o    = address_q;
  assign data_o       = data_q;
  assign flags_o      = flags_q;
  assign finish_mul_o = finish_q;

endmodule

// File: tb/tb_matmul_calc_engine.sv
module tb_matmul_calc_engine;

  logic        clk, rst, start, mode;
  logic [0:0]  n_dim, k_dim, m_dim;
  logic [15:0] data_a, data_b, data_c;
  logic [1:0]  rd_idx;
  logic        busy, enable_w, finish;
  logic [31:0] address;
  logic [15:0] data_w, flags;

  logic [15:0] tb_a [4];
  logic [15:0] tb_b [4];
  logic [15:0] tb_c [4];

  int tests_run = 0;
  int tests_failed = 0;

  int          wr_n, fin_cyc, max_rd;
  logic [31:0] wr_addr [8];
  logic [15:0] wr_data [8];
  int          wr_cyc  [8];

  assign data_a = tb_a[rd_idx];
  assign data_b = tb_b[rd_idx];
  assign data_c = tb_c[rd_idx];

  matmul_calc_engine #(.DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
    .n_dim_i(n_dim), .k_dim_i(k_dim), .m_dim_i(m_dim),
    .data_a_i(data_a), .data_b_i(data_b), .data_c_i(data_c),
    .rd_idx_o(rd_idx), .busy_o(busy), .enable_w_o(enable_w),
    .address_o(address), .data_o(data_w), .flags_o(flags),
    .finish_mul_o(finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts a job with a fresh start edge and records every write strobe.
  // Cycle numbers count the start edge as cycle 0.
  task automatic run_job(input logic md, input logic n, input logic k,
                         input logic m, input int budget);
    wr_n = 0; fin_cyc = -1; max_rd = 0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    mode = md; n_dim = n; k_dim = k; m_dim = m; start = 1'b1;
    for (int c = 0; c < budget && fin_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (enable_w) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] = address; wr_data[wr_n] = data_w; wr_cyc[wr_n] = c + 1;
        end
        wr_n++;
      end
      if (finish) fin_cyc = c + 1;
      if (int'(rd_idx) > max_rd) max_rd = int'(rd_idx);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; mode = 1'b1; n_dim = 1'b1; k_dim = 1'b1; m_dim = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (rd_idx !== 2'd0) begin tests_failed++; $display("FAIL reset_rd_idx got %0h want 0", rd_idx); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests_run++; if (enable_w !== 1'b0) begin tests_failed++; $display("FAIL reset_enable_w got %0b want 0", enable_w); end
    tests_run++; if (address !== 32'd0) begin tests_failed++; $display("FAIL reset_address got %0h want 0", address); end
    tests_run++; if (data_w !== 16'd0) begin tests_failed++; $display("FAIL reset_data got %0h want 0", data_w); end
    tests_run++; if (flags !== 16'd0) begin tests_failed++; $display("FAIL reset_flags got %0h want 0", flags); end
    tests_run++; if (finish !== 1'b0) begin tests_failed++; $display("FAIL reset_finish got %0b want 0", finish); end
    @(negedge clk); rst = 1'b0; start = 1'b0;
  endtask

  task automatic load_basic;
    tb_a[0] = 16'h0201; tb_a[1] = 16'h0403; tb_a[2] = 16'h0; tb_a[3] = 16'h0;
    tb_b[0] = 16'h0605; tb_b[1] = 16'h0807; tb_b[2] = 16'h0; tb_b[3] = 16'h0;
    tb_c[0] = 16'h0001; tb_c[1] = 16'h0001; tb_c[2] = 16'h0001; tb_c[3] = 16'h0001;
  endtask

  task automatic test_basic;
    logic [15:0] exp_d [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
    int          exp_c [4] = '{5, 7, 9, 11};
    int          held_wr;
    load_basic();
    run_job(1'b0, 1'b1, 1'b1, 1'b1, 40);
    tests_run++; if (wr_n !== 4) begin tests_failed++; $display("FAIL basic_write_count got %0d want 4", wr_n); end
    for (int e = 0; e < 4 && e < wr_n; e++) begin
      tests_run++; if (wr_data[e] !== exp_d[e]) begin tests_failed++; $display("FAIL basic_data[%0d] got %0d want %0d", e, wr_data[e], exp_d[e]); end
      tests_run++; if (wr_addr[e] !== 32'h10 + 32'(e) * 32'h20) begin tests_failed++; $display("FAIL basic_addr[%0d] got %0h want %0h", e, wr_addr[e], 32'h10 + 32'(e) * 32'h20); end
      tests_run++; if (wr_cyc[e] !== exp_c[e]) begin tests_failed++; $display("FAIL basic_write_cycle[%0d] got %0d want %0d", e, wr_cyc[e], exp_c[e]); end
    end
    tests_run++; if (flags !== 16'h0) begin tests_failed++; $display("FAIL basic_flags got %0h want 0", flags); end
    tests_run++; if (fin_cyc !== 12) begin tests_failed++; $display("FAIL basic_finish_cycle got %0d want 12", fin_cyc); end
    tests_run++; if (max_rd !== 1) begin tests_failed++; $display("FAIL basic_rd_idx_max got %0d want 1", max_rd); end
    // start held high through DONE must not restart
    held_wr = 0;
    repeat (4) begin @(posedge clk); #1; if (enable_w || busy) held_wr++; end
    tests_run++; if (held_wr !== 0) begin tests_failed++; $display("FAIL held_no_restart got %0d active cycles want 0", held_wr); end
    tests_run++; if (finish !== 1'b1) begin tests_failed++; $display("FAIL held_finish got %0b want 1", finish); end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (finish !== 1'b0) begin tests_failed++; $display("FAIL finish_drop got %0b want 0", finish); end
  endtask

  task automatic test_bias;
    logic [15:0] exp_d [4] = '{16'd20, 16'd23, 16'd44, 16'd51};
    int          exp_c [4] = '{7, 9, 11, 13};
    load_basic();
    run_job(1'b1, 1'b1, 1'b1, 1'b1, 40);
    tests_run++; if (wr_n !== 4) begin tests_failed++; $display("FAIL bias_write_count got %0d want 4", wr_n); end
    for (int e = 0; e < 4 && e < wr_n; e++) begin
      tests_run++; if (wr_data[e] !== exp_d[e]) begin tests_failed++; $display("FAIL bias_data[%0d] got %0d want %0d", e, wr_data[e], exp_d[e]); end
      tests_run++; if (wr_cyc[e] !== exp_c[e]) begin tests_failed++; $display("FAIL bias_write_cycle[%0d] got %0d want %0d", e, wr_cyc[e], exp_c[e]); end
    end
    tests_run++; if (fin_cyc !== 14) begin tests_failed++; $display("FAIL bias_finish_cycle got %0d want 14", fin_cyc); end
    tests_run++; if (max_rd !== 3) begin tests_failed++; $display("FAIL bias_load_length got %0d want 3", max_rd); end
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_overflow;
    logic [15:0] exp_v;
`ifdef MATMUL_SAT_EN
    exp_v = 16'h7FFF;
`else
    exp_v = 16'h8000;
`endif
    tb_a[0] = 16'h7F01; tb_b[0] = 16'h7F01; tb_c[0] = 16'h7FFF;
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 20);
    tests_run++; if (wr_n !== 1) begin tests_failed++; $display("FAIL ovf_write_count got %0d want 1", wr_n); end
    tests_run++; if (wr_data[0] !== exp_v) begin tests_failed++; $display("FAIL ovf_data got %0h want %0h", wr_data[0], exp_v); end
    tests_run++; if (wr_cyc[0] !== 3) begin tests_failed++; $display("FAIL ovf_write_cycle got %0d want 3", wr_cyc[0]); end
    tests_run++; if (fin_cyc !== 4) begin tests_failed++; $display("FAIL ovf_finish_cycle got %0d want 4", fin_cyc); end
    tests_run++; if (flags !== 16'h0001) begin tests_failed++; $display("FAIL ovf_flags got %0h want 0001", flags); end
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (flags !== 16'h0001) begin tests_failed++; $display("FAIL ovf_flags_hold got %0h want 0001", flags); end
  endtask

  task automatic test_rect;
    tb_a[0] = 16'h7F03; tb_a[1] = 16'h7FFE;
    tb_b[0] = 16'h7F04; tb_b[1] = 16'h7F7F;
    run_job(1'b0, 1'b1, 1'b0, 1'b0, 20);
    tests_run++; if (wr_n !== 2) begin tests_failed++; $display("FAIL rect_write_count got %0d want 2", wr_n); end
    tests_run++; if (wr_data[0] !== 16'd12 || wr_addr[0] !== 32'h10) begin tests_failed++; $display("FAIL rect_elem0 got %0h@%0h want 000c@10", wr_data[0], wr_addr[0]); end
    tests_run++; if (wr_data[1] !== 16'hFFF8 || wr_addr[1] !== 32'h50) begin tests_failed++; $display("FAIL rect_elem2 got %0h@%0h want fff8@50", wr_data[1], wr_addr[1]); end
    tests_run++; if (wr_cyc[0] !== 4 || wr_cyc[1] !== 5) begin tests_failed++; $display("FAIL rect_write_cycles got %0d,%0d want 4,5", wr_cyc[0], wr_cyc[1]); end
    tests_run++; if (fin_cyc !== 6) begin tests_failed++; $display("FAIL rect_finish_cycle got %0d want 6", fin_cyc); end
    @(negedge clk); start = 1'b0;
  endtask

  task automatic start_and_wait_write(output logic seen);
    seen = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    mode = 1'b0; n_dim = 1'b1; k_dim = 1'b1; m_dim = 1'b1; start = 1'b1;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(posedge clk); #1;
      if (enable_w) seen = 1'b1;
    end
  endtask

  task automatic test_abort;
    logic seen;
    int   extra_wr, extra_fin;
    load_basic();
    start_and_wait_write(seen);
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL abort_first_write got %0b want 1", seen); end
    start = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %0b want 0", busy); end
    extra_wr = 0; extra_fin = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (enable_w) extra_wr++;
      if (finish) extra_fin++;
    end
    tests_run++; if (extra_wr !== 0) begin tests_failed++; $display("FAIL abort_no_writes got %0d want 0", extra_wr); end
    tests_run++; if (extra_fin !== 0) begin tests_failed++; $display("FAIL abort_no_finish got %0d want 0", extra_fin); end
  endtask

  task automatic test_reset_during_write;
    logic seen;
    logic [15:0] exp_d [4] = '{16'd19, 16'd22, 16'd43, 16'd50};
    load_basic();
    start_and_wait_write(seen);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL rstw_first_write got %0b want 1", seen); end
    tests_run++; if ({rd_idx, busy, enable_w, finish} !== 5'd0) begin tests_failed++; $display("FAIL rstw_ctrl got %0h want 0", {rd_idx, busy, enable_w, finish}); end
    tests_run++; if (address !== 32'd0 || data_w !== 16'd0 || flags !== 16'd0) begin tests_failed++; $display("FAIL rstw_data got %0h/%0h/%0h want 0/0/0", address, data_w, flags); end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    run_job(1'b0, 1'b1, 1'b1, 1'b1, 40);
    tests_run++; if (wr_n !== 4) begin tests_failed++; $display("FAIL rstw_rerun_count got %0d want 4", wr_n); end
    for (int e = 0; e < 4 && e < wr_n; e++) begin
      tests_run++; if (wr_data[e] !== exp_d[e]) begin tests_failed++; $display("FAIL rstw_rerun_data[%0d] got %0d want %0d", e, wr_data[e], exp_d[e]); end
    end
    tests_run++; if (fin_cyc !== 12) begin tests_failed++; $display("FAIL rstw_rerun_finish got %0d want 12", fin_cyc); end
    @(negedge clk); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    n_dim = '0; k_dim = '0; m_dim = '0;
    for (int i = 0; i < 4; i++) begin tb_a[i] = '0; tb_b[i] = '0; tb_c[i] = '0; end
    test_reset();
    test_basic();
    test_bias();
    test_overflow();
    test_rect();
    test_abort();
    test_reset_during_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
